// File: rtl/mldsa_pkg.sv
// Shared ML-DSA constants: parameter-set encoding, matrix dimensions and seed layout.
package mldsa_pkg;

  localparam int unsigned SEED_BITS   = 256;
  // Byte positions of the column and row indices appended to rho
  localparam int unsigned SEED_BYTE_L = 32;
  localparam int unsigned SEED_BYTE_K = 33;

  typedef enum logic [1:0] {
    MLDSA_44 = 2'd0,
    MLDSA_65 = 2'd1,
    MLDSA_87 = 2'd2
  } mldsa_mode_e;

  // Row count K of the public matrix; 0 flags an illegal mode.
  function automatic logic [3:0] k_of(input logic [1:0] mode);
    case (mode)
      MLDSA_44: k_of = 4'd4;
      MLDSA_65: k_of = 4'd6;
      MLDSA_87: k_of = 4'd8;
      default:  k_of = 4'd0;
    endcase
  endfunction

  // Column count L of the public matrix; 0 flags an illegal mode.
  function automatic logic [3:0] l_of(input logic [1:0] mode);
    case (mode)
      MLDSA_44: l_of = 4'd4;
      MLDSA_65: l_of = 4'd5;
      MLDSA_87: l_of = 4'd7;
      default:  l_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/expand_a_seq.sv
// Walks the (k, l) indices of the ML-DSA public matrix A, issuing one RejNTTPoly
// run per polynomial with the seed rho || l || k, for a run-time selected parameter set.
module expand_a_seq #(
  parameter int unsigned SEED_BITS = mldsa_pkg::SEED_BITS,
  parameter int unsigned K_MAX     = 8,
  parameter int unsigned L_MAX     = 7,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned PIDX_W    = $clog2(K_MAX * L_MAX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   row_only,
  input  logic [IDX_W-1:0]       row_sel,
  input  logic [SEED_BITS-1:0]   rho,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [IDX_W-1:0]       k,
  output logic [IDX_W-1:0]       l,
  output logic [PIDX_W-1:0]      poly_idx,
  output logic                   samp_start,
  output logic [SEED_BITS+15:0]  samp_rho,
  output logic                   samp_abort,
  input  logic                   samp_done
);
  import mldsa_pkg::*;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     k_q, k_d, l_q, l_d;
  logic [PIDX_W-1:0]    pidx_q, pidx_d;
  logic [SEED_BITS+15:0] seed_q, seed_d;
  logic [IDX_W-1:0]     ll_q, last_k_q;
  logic                 err_q, err_d;
  logic                 samp_abort_q, samp_abort_d;
  logic                 cfg_load;

  logic [IDX_W-1:0]     k_sel, l_sel;
  logic                 illegal_cfg;
  logic                 last_pair;
  logic [SEED_BITS-1:0] rho_src;

  assign k_sel       = IDX_W'(k_of(mode));
  assign l_sel       = IDX_W'(l_of(mode));
  assign illegal_cfg = (mode == 2'd3) || (row_only && (row_sel >= k_sel));
  assign last_pair   = (k_q == last_k_q) && (l_q == ll_q - IDX_W'(1));

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    l_d          = l_q;
    pidx_d       = pidx_q;
    err_d        = 1'b0;
    samp_abort_d = 1'b0;
    cfg_load     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (illegal_cfg) begin
            err_d = 1'b1;
          end else begin
            cfg_load = 1'b1;
            k_d      = row_only ? row_sel : '0;
            l_d      = '0;
            pidx_d   = row_only ? PIDX_W'(PIDX_W'(row_sel) * PIDX_W'(l_sel)) : '0;
            state_d  = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (samp_done) begin
          if (last_pair) begin
            state_d = StFin;
          end else begin
            // Row-major order, so the linear index always advances by one
            if (l_q == ll_q - IDX_W'(1)) begin
              l_d = '0;
              k_d = k_q + IDX_W'(1);
            end else begin
              l_d = l_q + IDX_W'(1);
            end
            pidx_d  = pidx_q + PIDX_W'(1);
            state_d = StIssue;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides any index advance or completion in flight
    if (state_q != StIdle && abort) begin
      state_d      = StIdle;
      samp_abort_d = 1'b1;
      k_d          = k_q;
      l_d          = l_q;
      pidx_d       = pidx_q;
    end
  end

  // The low SEED_BITS of the seed register double as the latched rho
  always_comb begin
    rho_src                       = cfg_load ? rho : seed_q[SEED_BITS-1:0];
    seed_d                        = '0;
    seed_d[SEED_BITS-1:0]         = rho_src;
    seed_d[SEED_BYTE_L*8 +: 8]    = 8'(l_d);
    seed_d[SEED_BYTE_K*8 +: 8]    = 8'(k_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= '0;
      l_q          <= '0;
      pidx_q       <= '0;
      seed_q       <= '0;
      ll_q         <= '0;
      last_k_q     <= '0;
      err_q        <= 1'b0;
      samp_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      l_q          <= l_d;
      pidx_q       <= pidx_d;
      seed_q       <= seed_d;
      err_q        <= err_d;
      samp_abort_q <= samp_abort_d;
      if (cfg_load) begin
        ll_q     <= l_sel;
        last_k_q <= row_only ? row_sel : k_sel - IDX_W'(1);
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin) && !abort;
  assign samp_start = (state_q == StIssue);
  assign err        = err_q;
  assign samp_abort = samp_abort_q;
  assign k          = k_q;
  assign l          = l_q;
  assign poly_idx   = pidx_q;
  assign samp_rho   = seed_q;

endmodule

// File: tb/tb_expand_a_seq.sv
// Directed bench for expand_a_seq: an index-order model feeds a per-issue compare process,
// and directed tasks check start, done, err, abort and reset timing.
module tb_expand_a_seq;
  localparam int unsigned SEED_BITS = 256;
  localparam int unsigned K_MAX     = 8;
  localparam int unsigned L_MAX     = 7;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PIDX_W    = $clog2(K_MAX * L_MAX);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [1:0]            mode = 2'd0;
  logic                  row_only = 1'b0;
  logic [IDX_W-1:0]      row_sel = '0;
  logic [SEED_BITS-1:0]  rho = '0;
  logic                  abort = 1'b0;
  logic                  samp_done = 1'b0;
  logic                  busy, done, err, samp_start, samp_abort;
  logic [IDX_W-1:0]      k, l;
  logic [PIDX_W-1:0]     poly_idx;
  logic [SEED_BITS+15:0] samp_rho;

  expand_a_seq #(
    .SEED_BITS(SEED_BITS), .K_MAX(K_MAX), .L_MAX(L_MAX), .IDX_W(IDX_W), .PIDX_W(PIDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .row_only(row_only),
    .row_sel(row_sel), .rho(rho), .abort(abort), .busy(busy), .done(done), .err(err),
    .k(k), .l(l), .poly_idx(poly_idx), .samp_start(samp_start), .samp_rho(samp_rho),
    .samp_abort(samp_abort), .samp_done(samp_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int issue_cnt = 0;
  int done_cnt = 0;

  typedef struct {int k; int l; int p;} tup_t;
  tup_t                  expq[$];
  tup_t                  cmp_t;
  logic [SEED_BITS-1:0]  cur_rho = '0;
  logic [SEED_BITS+15:0] exp_seed;
  int                    kt[3] = '{4, 6, 8};
  int                    lt[3] = '{4, 5, 7};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void chk_seed(input string name, input logic [SEED_BITS+15:0] act,
                                   input logic [SEED_BITS+15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Polynomials in generation order, with their matA index k*L + l
  function automatic void plan(input int m, input bit ro, input int rs);
    int k0, k1;
    expq.delete();
    k0 = ro ? rs : 0;
    k1 = ro ? rs : kt[m] - 1;
    for (int kk = k0; kk <= k1; kk++)
      for (int ll = 0; ll < lt[m]; ll++)
        expq.push_back('{kk, ll, kk * lt[m] + ll});
  endfunction

  always @(negedge clk) begin
    if (rst_n && samp_start) begin
      issue_cnt++;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: samp_start=1 with no poly outstanding, required 0");
      end else begin
        cmp_t = expq.pop_front();
        exp_seed = {8'(cmp_t.k), 8'(cmp_t.l), cur_rho};
        chk("issue_k", 64'(k), 64'(cmp_t.k));
        chk("issue_l", 64'(l), 64'(cmp_t.l));
        chk("issue_poly_idx", 64'(poly_idx), 64'(cmp_t.p));
        chk("issue_busy", 64'(busy), 64'd1);
        chk_seed("issue_samp_rho", samp_rho, exp_seed);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_k"}, 64'(k), 64'd0);
    chk({tag, "_l"}, 64'(l), 64'd0);
    chk({tag, "_poly_idx"}, 64'(poly_idx), 64'd0);
    chk({tag, "_samp_start"}, 64'(samp_start), 64'd0);
    chk({tag, "_samp_abort"}, 64'(samp_abort), 64'd0);
    chk_seed({tag, "_samp_rho"}, samp_rho, '0);
  endtask

  // Returns at the negedge of the cycle after the start edge
  task automatic do_start(input logic [1:0] m, input bit ro, input int rs,
                          input logic [SEED_BITS-1:0] r, input bit legal);
    @(posedge clk); #1;
    mode = m; row_only = ro; row_sel = rs[IDX_W-1:0]; rho = r; start = 1'b1;
    if (legal) cur_rho = r;
    @(posedge clk); #1;
    start = 1'b0; rho = ~r;
    @(negedge clk);
    if (legal) begin
      chk("start_samp_start", 64'(samp_start), 64'd1);
      chk("start_busy", 64'(busy), 64'd1);
    end else begin
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_busy", 64'(busy), 64'd0);
      chk("err_no_issue", 64'(samp_start), 64'd0);
      @(negedge clk);
      chk("err_clear", 64'(err), 64'd0);
      chk("err_idle", 64'(busy), 64'd0);
    end
  endtask

  task automatic step(input int gap, input bit dn, input bit ab, input bit stray);
    repeat (gap) @(posedge clk);
    #1;
    samp_done = dn; abort = ab;
    if (stray) begin start = 1'b1; mode = 2'd2; end
    @(posedge clk); #1;
    samp_done = 1'b0; abort = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_polys(input int n, input int gap, input int abort_idx, input bit abort_only,
                           input int stray_idx);
    int dc0;
    dc0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      step(gap, !(i == abort_idx && abort_only), i == abort_idx, i == stray_idx);
      if (i == abort_idx) begin
        chk("abort_samp_abort", 64'(samp_abort), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_no_issue", 64'(samp_start), 64'd0);
        expq.delete();
        @(negedge clk);
        chk("abort_samp_abort_clear", 64'(samp_abort), 64'd0);
        chk("abort_no_done", 64'(done_cnt), 64'(dc0));
        return;
      end else if (i == n - 1) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_fin", 64'(busy), 64'd1);
        @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
        chk("all_issued", 64'(expq.size()), 64'd0);
        chk("one_done", 64'(done_cnt), 64'(dc0 + 1));
      end else begin
        chk("next_issue", 64'(samp_start), 64'd1);
      end
    end
  endtask

  logic [SEED_BITS-1:0] rho_a;
  logic [SEED_BITS-1:0] rho_b;
  int ic0;

  initial begin
    rho_a = {4{64'h1234567890abcdef}};
    rho_b = {8{32'hdeadbeef}};

    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // abort while idle
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", 64'(samp_abort), 64'd0);
    chk("idle_abort_busy", 64'(busy), 64'd0);

    // ML-DSA-44 full matrix
    plan(0, 1'b0, 0);
    chk("model_size_44", 64'(expq.size()), 64'd16);
    chk("model_last_44_p", 64'(expq[15].p), 64'd15);
    ic0 = issue_cnt;
    do_start(2'd0, 1'b0, 0, rho_a, 1'b1);
    chk_seed("first_seed_literal", samp_rho, {16'h0000, rho_a});
    run_polys(16, 3, -1, 1'b0, -1);
    chk("issues_44", 64'(issue_cnt - ic0), 64'd16);

    // ML-DSA-65 single row 5
    plan(1, 1'b1, 5);
    chk("model_row5_first_p", 64'(expq[0].p), 64'd25);
    chk("model_row5_last_p", 64'(expq[4].p), 64'd29);
    chk("model_row5_k", 64'(expq[4].k), 64'd5);
    ic0 = issue_cnt;
    do_start(2'd1, 1'b1, 5, rho_b, 1'b1);
    chk("row5_k_literal", 64'(k), 64'd5);
    chk("row5_pidx_literal", 64'(poly_idx), 64'd25);
    run_polys(5, 2, -1, 1'b0, -1);
    chk("issues_row5", 64'(issue_cnt - ic0), 64'd5);

    // ML-DSA-87 full matrix, back-to-back sampler
    plan(2, 1'b0, 0);
    chk("model_size_87", 64'(expq.size()), 64'd56);
    chk("model_last_87_p", 64'(expq[55].p), 64'd55);
    ic0 = issue_cnt;
    do_start(2'd2, 1'b0, 0, rho_a, 1'b1);
    run_polys(56, 1, -1, 1'b0, -1);
    chk("issues_87", 64'(issue_cnt - ic0), 64'd56);

    // illegal configurations
    expq.delete();
    do_start(2'd3, 1'b0, 0, rho_b, 1'b0);
    do_start(2'd0, 1'b1, 4, rho_b, 1'b0);
    do_start(2'd1, 1'b1, 6, rho_b, 1'b0);

    // abort in WAIT of poly 7
    plan(0, 1'b0, 0);
    do_start(2'd0, 1'b0, 0, rho_b, 1'b1);
    run_polys(16, 2, 7, 1'b1, -1);

    // abort together with the final samp_done of a single-row run
    plan(0, 1'b1, 3);
    do_start(2'd0, 1'b1, 3, rho_a, 1'b1);
    run_polys(4, 2, 3, 1'b0, -1);

    // restart from (0,0), with a stray start mid-run that must be ignored
    plan(0, 1'b0, 0);
    do_start(2'd0, 1'b0, 0, rho_b, 1'b1);
    chk("restart_k", 64'(k), 64'd0);
    chk("restart_l", 64'(l), 64'd0);
    run_polys(16, 1, -1, 1'b0, 2);

    // reset asserted mid-run
    plan(1, 1'b0, 0);
    do_start(2'd1, 1'b0, 0, rho_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(2, 1'b1, 1'b0, 1'b0);
      chk("pre_reset_issue", 64'(samp_start), 64'd1);
    end
    @(posedge clk); #2;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("midrun_reset");
    expq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
